// File: rtl/regs52_piso.sv
// regs52_piso: parallel-in serial-out frame unloader; define REGS52_PISO_LAST_EN to add dout_last
module regs52_piso #(
    parameter int DATA_WIDTH = 28,
    parameter int REGDEPTH   = 52
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*REGDEPTH-1:0] din_flat,
    input  logic                           load_valid,
    output logic                           load_ready,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
`ifdef REGS52_PISO_LAST_EN
    output logic                           dout_last,
`endif
    output logic                           busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [5:0] LAST  = 6'(REGDEPTH - 1);

    logic [0:0]                             state_q, state_d;
    logic [5:0]                             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  dout_q, dout_d;
    logic [REGDEPTH-1:0][DATA_WIDTH-1:0]    frame_q, frame_d;
    logic                                   last_beat, load_fire, beat_fire;
    logic [5:0]                             nxt_idx;

    assign last_beat  = cnt_q == LAST;
    // A new frame may land on the last beat of the current one, so the next frame follows without a bubble.
    assign load_ready = !rst && (state_q == IDLE || (last_beat && dout_ready));
    assign load_fire  = load_valid && load_ready;
    assign beat_fire  = state_q == SHIFT && dout_ready;
    // Word index of slot REGDEPTH-1-(cnt+1); only used while cnt is below the last beat.
    assign nxt_idx    = LAST - 6'd1 - cnt_q;
    assign dout       = dout_q;
    assign dout_valid = state_q == SHIFT;
    assign busy       = state_q == SHIFT;
`ifdef REGS52_PISO_LAST_EN
    assign dout_last  = state_q == SHIFT && last_beat;
`endif

    // Next-state: a load takes priority, otherwise an accepted beat advances or finishes the frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        frame_d = frame_q;
        if (load_fire) begin
            frame_d = din_flat;
            cnt_d   = '0;
            dout_d  = din_flat[(REGDEPTH-1)*DATA_WIDTH +: DATA_WIDTH];
            state_d = SHIFT;
        end else if (beat_fire) begin
            if (!last_beat) begin
                cnt_d  = cnt_q + 6'd1;
                dout_d = frame_q[nxt_idx];
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State registers; reset aborts any frame in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: tb/tb_regs52_piso.sv
// tb_regs52_piso: directed table-driven bench for regs52_piso (covers dout_last when REGS52_PISO_LAST_EN is defined)
module tb_regs52_piso;
    localparam int W = 28;
    localparam int D = 52;

    logic             clk = 1'b0;
    logic             rst;
    logic [W*D-1:0]   din_flat;
    logic             load_valid, load_ready, dout_valid, dout_ready, busy;
    logic [W-1:0]     dout;
`ifdef REGS52_PISO_LAST_EN
    logic             dout_last;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rdy;
        logic [W-1:0] dout;
        logic         valid;
        logic         busy;
        logic         lready;
        logic         last;
    } vec_t;
    vec_t tbl [D+1];

    logic [W*D-1:0] fk, fa, fb, fr;
    logic [W-1:0]   taps [1:D];

    regs52_piso #(.DATA_WIDTH(W), .REGDEPTH(D)) dut (
        .clk(clk), .rst(rst), .din_flat(din_flat), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready),
`ifdef REGS52_PISO_LAST_EN
        .dout_last(dout_last),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_frame(input logic [W*D-1:0] f);
        din_flat   = f;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        dout_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {63'd0, dout_valid}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_slot, acc, cyc;
        logic [W-1:0] exp_w;
        for (int k = 0; k < D; k++) begin
            fk[k*W +: W] = W'(k + 1);
            fa[k*W +: W] = 28'h0AAAAAA;
            fb[k*W +: W] = 28'h1000000 + W'(k + 1);
            fr[k*W +: W] = W'($urandom);
        end
        for (int i = 0; i < D; i++)
            tbl[i] = '{1'b1, W'(D - i), 1'b1, 1'b1, i == D - 1, i == D - 1};
        tbl[D] = '{1'b1, W'(1), 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; load_valid = 1'b0; dout_ready = 1'b0; din_flat = '0;
        #2;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lready", 64'(load_ready), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_lready", 64'(load_ready), 64'd1);

        // frame k with dout_ready held high
        load_frame(fk);
        for (int i = 0; i <= D; i++) begin
            dout_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t1_dout[%0d]", i), 64'(dout), 64'(tbl[i].dout));
            chk($sformatf("t1_valid[%0d]", i), 64'(dout_valid), 64'(tbl[i].valid));
            chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("t1_lready[%0d]", i), 64'(load_ready), 64'(tbl[i].lready));
`ifdef REGS52_PISO_LAST_EN
            chk($sformatf("t1_last[%0d]", i), 64'(dout_last), 64'(tbl[i].last));
`endif
            @(posedge clk); #1;
        end

        // 1-on/2-off back-pressure
        load_frame(fk);
        exp_slot = D; acc = 0; cyc = 0;
        while (acc < D && cyc < 400) begin
            dout_ready = (cyc % 3) == 0;
            @(negedge clk);
            if (dout_valid) begin
                chk("t2_dout", 64'(dout), 64'(exp_slot));
                if (dout_ready) begin
                    exp_slot--;
                    acc++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("t2_beats", 64'(acc), 64'(D));
        @(negedge clk);
        chk("t2_valid_drop", 64'(dout_valid), 64'd0);
        @(posedge clk); #1;

        // loopback into a 52-tap delay line model
        for (int j = 1; j <= D; j++) taps[j] = '0;
        load_frame(fr);
        acc = 0; cyc = 0;
        while (acc < D && cyc < 400) begin
            dout_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (dout_valid && dout_ready) begin
                for (int j = D; j > 1; j--) taps[j] = taps[j-1];
                taps[1] = dout;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("t3_beats", 64'(acc), 64'(D));
        for (int j = 1; j <= D; j++)
            chk($sformatf("t3_reg%02d", j), 64'(taps[j]), 64'(fr[(j-1)*W +: W]));
        drain();

        // back-to-back frames A then B with load_valid held
        dout_ready = 1'b1;
        load_frame(fa);
        din_flat = fb; load_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("t4_a_dout", 64'(dout), 64'h0AAAAAA);
            chk("t4_a_valid", 64'(dout_valid), 64'd1);
            chk($sformatf("t4_a_lready[%0d]", i), 64'(load_ready), 64'(i == D - 1));
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk($sformatf("t4_b_dout[%0d]", i), 64'(dout), 64'h1000000 + 64'(D - i));
            chk("t4_b_valid", 64'(dout_valid), 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t4_end_valid", 64'(dout_valid), 64'd0);
        @(posedge clk); #1;

        // asynchronous reset at beat 20
        load_frame(fk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_dout", 64'(dout), 64'd0);
        chk("t5_rst_valid", 64'(dout_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_lready", 64'(load_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rel_lready", 64'(load_ready), 64'd1);
        @(posedge clk); #1;
        load_frame(fk);
        @(negedge clk);
        chk("t5_first", 64'(dout), 64'd52);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_second", 64'(dout), 64'd51);
        @(posedge clk); #1;
        drain();

`ifdef REGS52_PISO_LAST_EN
        // dout_last held across a 3-cycle stall on the final beat
        dout_ready = 1'b1;
        load_frame(fk);
        for (int i = 0; i < D - 1; i++) begin
            @(negedge clk);
            chk("t6_last_low", 64'(dout_last), 64'd0);
            @(posedge clk); #1;
        end
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_last_hold", 64'(dout_last), 64'd1);
            chk("t6_dout_hold", 64'(dout), 64'd1);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        @(negedge clk);
        chk("t6_last_fire", 64'(dout_last), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_last_after", 64'(dout_last), 64'd0);
        chk("t6_valid_after", 64'(dout_valid), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
